// File: rtl/multiword_add_seq.sv
// multiword_add_seq: sequential WORDS*32-bit adder.
// Operands arrive over one valid/ready handshake. A 32-bit carry-skip adder
// then processes one word per clock, least significant word first, and the
// carry is registered between words. The finished sum and the final carry
// leave over a second valid/ready handshake and stay stable until taken.

// 32-bit carry-skip adder built from eight 4-bit ripple groups.
// A group whose bits all propagate passes its carry-in straight to the
// next group, so a long carry chain can skip whole groups.
module skip_adder32 (
    output logic [31:0] s,
    output logic        co,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci
);

    logic blk_c_s;
    logic rc_s;
    logic grp_p_s;

    // Ripple inside each group; skip a group when all of its bits propagate.
    always_comb begin
        blk_c_s = ci;
        rc_s    = 1'b0;
        grp_p_s = 1'b0;
        s       = 32'd0;
        for (int g = 0; g < 8; g++) begin
            rc_s    = blk_c_s;
            grp_p_s = 1'b1;
            for (int i = 0; i < 4; i++) begin
                s[g*4+i] = a[g*4+i] ^ b[g*4+i] ^ rc_s;
                rc_s     = (a[g*4+i] & b[g*4+i]) | (rc_s & (a[g*4+i] ^ b[g*4+i]));
                grp_p_s  = grp_p_s & (a[g*4+i] ^ b[g*4+i]);
            end
            blk_c_s = grp_p_s ? blk_c_s : rc_s;
        end
        co = blk_c_s;
    end

endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDS*32-1:0]  in_a,
    input  logic [WORDS*32-1:0]  in_b,
    input  logic                 in_ci,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDS*32-1:0]  out_sum,
    output logic                 out_co,
    output logic                 busy
);

    localparam int W     = WORDS * 32;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       sum_r;
    logic               co_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [31:0]        word_a_s;
    logic [31:0]        word_b_s;
    logic [31:0]        word_s_s;
    logic               word_co_s;
    logic               last_word_s;
    logic               accept_s;

    assign last_word_s = (idx_r == IDX_W'(WORDS - 1));
    assign accept_s    = (state_r == ST_IDLE) && in_valid;

    // Select the current word of each held operand (AND-OR mux over words).
    always_comb begin
        word_a_s = 32'd0;
        word_b_s = 32'd0;
        for (int w = 0; w < WORDS; w++) begin
            word_a_s = word_a_s | (a_r[w*32 +: 32] & {32{idx_r == IDX_W'(w)}});
            word_b_s = word_b_s | (b_r[w*32 +: 32] & {32{idx_r == IDX_W'(w)}});
        end
    end

    skip_adder32 u_adder (
        .s  (word_s_s),
        .co (word_co_s),
        .a  (word_a_s),
        .b  (word_b_s),
        .ci (carry_r)
    );

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last word,
    // DONE -> IDLE only when the consumer takes the result.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_word_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Datapath: capture operands on accept, then add one word per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            co_r    <= 1'b0;
        end else if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_ci;
            idx_r   <= '0;
        end else if (state_r == ST_RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_r == IDX_W'(w)) begin
                    sum_r[w*32 +: 32] <= word_s_s;
                end
            end
            carry_r <= word_co_s;
            if (last_word_s) begin
                co_r <= word_co_s;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_sum   = sum_r;
    assign out_co    = co_r;

endmodule
